// File: rtl/complex_acc_pkg.sv
// Shared definitions for the complex accumulator and its upstream complex multiplier.
package complex_acc_pkg;

  // Accumulator FSM state encoding.
  typedef logic [0:0] state_t;
  localparam state_t ACC  = 1'b0;
  localparam state_t HOLD = 1'b1;

  // Packed complex bus: real part in the low half, imaginary part above it.
  localparam int unsigned REAL_LSB = 0;

  // Width of one product component for a given multiplier operand width.
  function automatic int unsigned comp_width(int unsigned size);
    return 3 * size / 2;
  endfunction

  // Bit offset of the imaginary component inside a packed product bus.
  function automatic int unsigned imag_lsb(int unsigned size);
    return REAL_LSB + comp_width(size);
  endfunction

  // Accumulator component width: product component plus guard bits.
  function automatic int unsigned acc_width(int unsigned size, int unsigned guard);
    return comp_width(size) + guard;
  endfunction

endpackage

// File: rtl/complex_add_ext.sv
// Combinational sign-extend-and-add of a packed complex product onto a packed accumulator.
module complex_add_ext
  import complex_acc_pkg::*;
#(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned ACC_W = 27
) (
  input  logic [3*SIZE-1:0]  sample,
  input  logic [2*ACC_W-1:0] acc,
  output logic [2*ACC_W-1:0] sum
);

  localparam int unsigned IN_W   = comp_width(SIZE);
  localparam int unsigned IM_LSB = imag_lsb(SIZE);

  logic signed [IN_W-1:0]  re_in;
  logic signed [IN_W-1:0]  im_in;
  logic signed [ACC_W-1:0] re_ext;
  logic signed [ACC_W-1:0] im_ext;
  logic signed [ACC_W-1:0] re_acc;
  logic signed [ACC_W-1:0] im_acc;
  logic signed [ACC_W-1:0] re_sum;
  logic signed [ACC_W-1:0] im_sum;

  assign re_in  = sample[REAL_LSB +: IN_W];
  assign im_in  = sample[IM_LSB +: IN_W];

  // Signed casts widen with the sign bit replicated.
  assign re_ext = ACC_W'(re_in);
  assign im_ext = ACC_W'(im_in);

  assign re_acc = acc[ACC_W-1:0];
  assign im_acc = acc[2*ACC_W-1:ACC_W];

  // Real and imaginary adders operate independently.
  assign re_sum = re_acc + re_ext;
  assign im_sum = im_acc + im_ext;

  assign sum    = {im_sum, re_sum};

endmodule

// File: rtl/complex_acc.sv
// Streaming complex accumulator: sums FRAME_LEN accepted products per output frame and
// presents each sum on a valid/ready handshake, flagging products dropped while busy.
module complex_acc
  import complex_acc_pkg::*;
#(
  parameter int unsigned  SIZE      = 16,
  parameter int unsigned  FRAME_LEN = 8,
  parameter int unsigned  GUARD     = 3,
  localparam int unsigned ACC_W     = acc_width(SIZE, GUARD),
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [3*SIZE-1:0]  in_data,
  output logic               in_ready,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*ACC_W-1:0] out_data,
  output logic [CNT_W-1:0]   count,
  output logic               overrun
);

  // Reject parameter sets that could overflow the accumulator or split the bus unevenly.
  if (FRAME_LEN < 1 || GUARD > 30 || FRAME_LEN > (32'd1 << GUARD)) begin : g_bad_frame_len
    $error("complex_acc: FRAME_LEN must lie in 1..2**GUARD");
  end
  if (SIZE < 2 || (SIZE % 2) != 0) begin : g_bad_size
    $error("complex_acc: SIZE must be even and at least 2");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t             state_q, state_d;
  logic [2*ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic [2*ACC_W-1:0] out_data_q, out_data_d;
  logic               overrun_q, overrun_d;

  logic [2*ACC_W-1:0] acc_base;
  logic [2*ACC_W-1:0] acc_sum;
  logic               accept;

  assign in_ready = !out_valid_q;
  assign accept   = in_valid && in_ready;

  // First product of a frame loads directly so no stale partial sum can leak in.
  assign acc_base = (count_q == '0) ? '0 : acc_q;

  complex_add_ext #(
    .SIZE  (SIZE),
    .ACC_W (ACC_W)
  ) u_add (
    .sample (in_data),
    .acc    (acc_base),
    .sum    (acc_sum)
  );

  // Next-state logic: clear overrides everything, including a same-cycle accept or handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;

    if (clear) begin
      state_d     = ACC;
      acc_d       = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        overrun_d = 1'b1;
      end
      case (state_q)
        ACC: begin
          if (accept) begin
            if (count_q == LAST) begin
              out_data_d  = acc_sum;
              out_valid_d = 1'b1;
              acc_d       = '0;
              count_d     = '0;
              state_d     = HOLD;
            end else begin
              acc_d   = acc_sum;
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
          end
        end
        default: begin
          state_d = ACC;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_complex_acc.sv
// Self-checking bench for complex_acc: randomized and directed stimulus, frame-level
// reference model feeding a scoreboard that a separate monitor drains.
module tb_complex_acc;

  localparam int unsigned SIZE      = 16;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned GUARD     = 3;
  localparam int unsigned ACC_W     = 27;
  localparam int unsigned CNT_W     = 4;

  typedef struct {
    int re;
    int im;
  } cplx_t;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic [3*SIZE-1:0]  in_data;
  logic               in_ready;
  logic               clear;
  logic               out_valid;
  logic               out_ready;
  logic [2*ACC_W-1:0] out_data;
  logic [CNT_W-1:0]   count;
  logic               overrun;

  int in_re;
  int in_im;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  cplx_t frame_q[$];
  cplx_t exp_q[$];
  bit    m_hold;
  bit    m_ovr;

  // Monitor state.
  bit                 seen;
  logic [2*ACC_W-1:0] held;
  int                 pres_cnt = 0;
  int                 last_re;
  int                 last_im;

  assign in_data = {in_im[23:0], in_re[23:0]};

  complex_acc #(
    .SIZE      (SIZE),
    .FRAME_LEN (FRAME_LEN),
    .GUARD     (GUARD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: collect accepted products, sum a full frame with plain integers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q.delete();
      exp_q.delete();
      m_hold = 1'b0;
      m_ovr  = 1'b0;
    end else if (clear) begin
      frame_q.delete();
      m_hold = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      if (in_valid && m_hold) m_ovr = 1'b1;
      if (m_hold) begin
        if (out_ready) m_hold = 1'b0;
      end else if (in_valid) begin
        frame_q.push_back('{re: in_re, im: in_im});
        if (frame_q.size() == FRAME_LEN) begin
          cplx_t s;
          s.re = 0;
          s.im = 0;
          foreach (frame_q[i]) begin
            s.re += frame_q[i].re;
            s.im += frame_q[i].im;
          end
          exp_q.push_back(s);
          frame_q.delete();
          m_hold = 1'b1;
        end
      end
    end
  end

  // Monitor: samples on the falling edge, pops one expected sum per presentation.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      chk("out_valid", out_valid, m_hold);
      chk("in_ready", in_ready, !m_hold);
      chk("count", count, frame_q.size());
      chk("overrun", overrun, m_ovr);
      if (out_valid) begin
        if (!seen) begin
          cplx_t e;
          int    a_re;
          int    a_im;
          a_re = int'($signed(out_data[ACC_W-1:0]));
          a_im = int'($signed(out_data[2*ACC_W-1:ACC_W]));
          if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk("sum_real", a_re, e.re);
            chk("sum_imag", a_im, e.im);
          end
          last_re = a_re;
          last_im = a_im;
          held    = out_data;
          seen    = 1'b1;
          pres_cnt++;
        end else begin
          chk("out_data_stable", out_data, held);
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic step(input logic v, input int re, input int im, input logic clr,
                      input logic ordy);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_re     = re;
    in_im     = im;
    clear     = clr;
    out_ready = ordy;
  endtask

  task automatic wait_pres(input int prev, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      #1;
      if (pres_cnt > prev) got = 1'b1;
    end
    if (!got) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic check_last(input string name, input int re, input int im);
    chk({name, "_real"}, last_re, re);
    chk({name, "_imag"}, last_im, im);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_in_ready"}, in_ready, 1);
    chk({name, "_count"}, count, 0);
    chk({name, "_overrun"}, overrun, 0);
    chk({name, "_out_data"}, out_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p;
    logic [23:0] r;
    logic [23:0] q;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = 0;
    in_im     = 0;
    clear     = 1'b0;
    out_ready = 1'b1;
    #3;
    check_reset_outputs("reset");
    #9;
    rst_n = 1'b1;

    // 1: basic frame of (1, 2).
    p = pres_cnt;
    for (int k = 0; k < 8; k++) step(1, 1, 2, 0, 1);
    step(0, 0, 0, 0, 1);
    wait_pres(p, "t1");
    check_last("t1", 8, 16);
    chk("t1_count", count, 0);

    // 2: extreme component values, no wrap in the guard bits.
    p = pres_cnt;
    for (int k = 0; k < 8; k++) step(1, -1, 8388607, 0, 1);
    step(0, 0, 0, 0, 1);
    wait_pres(p, "t2");
    check_last("t2", -8, 67108856);

    // 3: back-pressure with products still arriving sets overrun and drops them.
    p = pres_cnt;
    for (int k = 0; k < 8; k++) step(1, k, -k, 0, 0);
    for (int k = 0; k < 5; k++) step(1, 100, 100, 0, 0);
    @(negedge clk);
    #1;
    chk("t3_in_ready", in_ready, 0);
    chk("t3_overrun", overrun, 1);
    check_last("t3", 28, -28);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("t3_released", in_ready, 1);

    // 4: clear discards a partial frame and the same-cycle product, and clears overrun.
    p = pres_cnt;
    for (int k = 0; k < 3; k++) step(1, 5, 5, 0, 1);
    step(1, 9, 9, 1, 1);
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    wait_pres(p, "t4");
    check_last("t4", 8, 0);
    chk("t4_overrun", overrun, 0);

    // 5: asynchronous reset mid-frame.
    for (int k = 0; k < 4; k++) step(1, 3, 0, 0, 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    p = pres_cnt;
    for (int k = 0; k < 8; k++) step(1, 3, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    wait_pres(p, "t5");
    check_last("t5", 24, 0);

    // 6: gapped input, sum held until downstream accepts.
    p = pres_cnt;
    for (int k = 0; k < 8; k++) begin
      step(1, -2, 7, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_last("t6", -16, 56);
    chk("t6_single_assertion", pres_cnt - p, 1);

    // Randomized traffic with back-pressure and occasional clears.
    for (int k = 0; k < 500; k++) begin
      r = 24'($urandom);
      q = 24'($urandom);
      step($urandom_range(0, 9) < 7, int'($signed(r)), int'($signed(q)),
           $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6);
    end
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
